// File: rtl/sys_array_drain.sv
// Reader side of the systolic array result bus: snapshots the full out_c matrix
// on a capture pulse and streams it out one PE row per valid/ready beat.
module sys_array_drain #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  localparam int IDX_W     = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1,
  localparam int ROW_W     = ARR_WIDTH * WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ARR_HEIGHT*ROW_W-1:0] in_c,
  input  logic                        capture,
  output logic [ROW_W-1:0]            out_row_data,
  output logic [IDX_W-1:0]            out_row_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);
  // state | meaning
  // IDLE  | waiting for capture, no beat offered
  // SEND  | streaming buffered rows, out_valid held high until each transfer
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ARR_HEIGHT - 1);

  state_t                           state_q, state_d;
  logic [ARR_HEIGHT-1:0][ROW_W-1:0] buf_q;
  logic [IDX_W-1:0]                 row_q, row_d;
  logic                             load, last_row, last_xfer, done_d, overrun_d;

  assign last_row     = (row_q == LAST_ROW);
  assign busy         = (state_q == SEND);
  assign out_valid    = busy;
  assign out_last     = busy && last_row;
  assign out_row_idx  = row_q;
  assign out_row_data = busy ? buf_q[row_q] : '0;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    load      = 1'b0;
    last_xfer = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun;
    case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          row_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        last_xfer = out_ready && last_row;
        if (out_ready) begin
          if (last_row) begin
            done_d = 1'b1;
            row_d  = '0;
            // a capture on the final transfer chains straight into the next drain
            if (capture) load = 1'b1;
            else         state_d = IDLE;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
        if (capture && !last_xfer) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (load) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      buf_q   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      done    <= done_d;
      overrun <= overrun_d;
      if (load) buf_q <= in_c;
    end
  end

endmodule

// File: tb/tb_sys_array_drain.sv
// Bench for sys_array_drain: directed scenarios then random backpressure drains,
// every cycle compared against a matrix/beat-count reference model.
module tb_sys_array_drain;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int RW = AW * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          capture = 1'b0;
  logic          out_ready = 1'b0;
  logic [H*RW-1:0] in_c = '0;
  logic [RW-1:0] out_row_data;
  logic [1:0]    out_row_idx;
  logic          out_valid, out_last, busy, done, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] drv_el [H][AW];
  logic [W-1:0] m_snap [H][AW];
  int m_rem, drains, accepts, beats_seen;
  bit m_done, m_ovr;

  always #5 clk = ~clk;

  sys_array_drain #(.WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_c(in_c), .capture(capture),
    .out_row_data(out_row_data), .out_row_idx(out_row_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pattern(input int base);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < AW; j++)
        drv_el[i][j] = W'(base + 256 * i + j);
  endtask

  task automatic set_const(input logic [W-1:0] v);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < AW; j++)
        drv_el[i][j] = v;
  endtask

  task automatic set_random();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < AW; j++)
        drv_el[i][j] = W'($urandom());
  endtask

  task automatic drive_in();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < AW; j++)
        in_c[(i * AW + j) * W +: W] = drv_el[i][j];
  endtask

  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < AW; j++) v[j * W +: W] = m_snap[r][j];
    return v;
  endfunction

  task automatic model_reset();
    m_rem  = 0;
    m_done = 1'b0;
    m_ovr  = 1'b0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < AW; j++)
        m_snap[i][j] = '0;
  endtask

  task automatic check_outputs();
    bit v;
    int r;
    v = (m_rem > 0);
    r = H - m_rem;
    chk("valid",   64'(out_valid), 64'(v));
    chk("busy",    64'(busy),      64'(v));
    chk("done",    64'(done),      64'(m_done));
    chk("overrun", 64'(overrun),   64'(m_ovr));
    if (v) begin
      chk("row_idx",  64'(out_row_idx),  64'(r));
      chk("row_data", 64'(out_row_data), 64'(exp_row(r)));
      chk("last",     64'(out_last),     64'(r == H - 1));
    end else begin
      chk("last_idle", 64'(out_last), 64'(0));
    end
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge, then check.
  task automatic cycle(input bit rdy, input bit cap);
    bit v, lx, acc;
    out_ready = rdy;
    capture   = cap;
    drive_in();
    if (out_valid && rdy) beats_seen++;
    v   = (m_rem > 0);
    lx  = v && rdy && (m_rem == 1);
    acc = cap && (!v || lx);
    if (cap && v && !lx) m_ovr = 1'b1;
    if (v && rdy) m_rem--;
    m_done = lx;
    if (lx) drains++;
    if (acc) begin
      m_rem  = H;
      m_snap = drv_el;
      m_ovr  = 1'b0;
      accepts++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},    64'(out_row_data), 64'(0));
    chk({tag, "_idx"},     64'(out_row_idx),  64'(0));
    chk({tag, "_valid"},   64'(out_valid),    64'(0));
    chk({tag, "_last"},    64'(out_last),     64'(0));
    chk({tag, "_busy"},    64'(busy),         64'(0));
    chk({tag, "_done"},    64'(done),         64'(0));
    chk({tag, "_overrun"}, 64'(overrun),      64'(0));
  endtask

  initial begin
    int d0, a0, b0;
    bit rdy, cap;
    drains = 0; accepts = 0; beats_seen = 0;
    model_reset();
    set_pattern(0);
    drive_in();
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 0);
    cycle(1, 0);

    // basic drain
    set_pattern(0);
    cycle(1, 1);
    chk("t1_row0_idx", 64'(out_row_idx), 64'(0));
    cycle(1, 0);
    cycle(1, 0);
    chk("t1_row2_data", 64'(out_row_data), 64'h0203_0202_0201_0200);
    chk("t1_row2_last", 64'(out_last), 64'(0));
    cycle(1, 0);
    chk("t1_row3_last", 64'(out_last), 64'(1));
    cycle(1, 0);
    chk("t1_done", 64'(done), 64'(1));
    cycle(1, 0);
    chk("t1_done_pulse", 64'(done), 64'(0));

    // backpressure on row 1
    set_pattern(16'h0400);
    cycle(1, 1);
    cycle(1, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0);
    chk("t2_hold_idx",   64'(out_row_idx), 64'(1));
    chk("t2_hold_valid", 64'(out_valid),   64'(1));
    cycle(1, 0);
    cycle(1, 0);
    cycle(1, 0);
    chk("t2_done", 64'(done), 64'(1));

    // isolation and overrun
    set_pattern(0);
    cycle(1, 1);
    cycle(1, 0);
    set_const(16'hFFFF);
    cycle(0, 1);
    chk("t3_overrun_set", 64'(overrun), 64'(1));
    cycle(1, 0);
    chk("t3_row2_isolated", 64'(out_row_data), 64'h0203_0202_0201_0200);
    cycle(1, 0);
    cycle(1, 0);
    chk("t3_overrun_sticky", 64'(overrun), 64'(1));
    cycle(1, 1);
    chk("t3_overrun_clear", 64'(overrun), 64'(0));
    chk("t3_new_row0", 64'(out_row_data), 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 4; k++) cycle(1, 0);

    // back-to-back capture on last beat
    set_pattern(16'h1000);
    cycle(1, 1);
    for (int k = 0; k < 3; k++) cycle(1, 0);
    set_pattern(16'h2000);
    cycle(1, 1);
    chk("t4_done",    64'(done),         64'(1));
    chk("t4_valid",   64'(out_valid),    64'(1));
    chk("t4_idx",     64'(out_row_idx),  64'(0));
    chk("t4_data",    64'(out_row_data), 64'h2003_2002_2001_2000);
    chk("t4_overrun", 64'(overrun),      64'(0));
    for (int k = 0; k < 4; k++) cycle(1, 0);

    // reset mid-drain
    set_pattern(16'h3000);
    cycle(1, 1);
    cycle(1, 0);
    cycle(1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("t5_async");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1, 0);
    chk("t5_no_done", 64'(done), 64'(0));

    // random backpressure over 20 drains
    d0 = drains; a0 = accepts; b0 = beats_seen;
    for (int c = 0; c < 4000 && (drains - d0) < 20; c++) begin
      rdy = ($urandom_range(0, 99) < 65);
      cap = ((accepts - a0) < 20) && ($urandom_range(0, 99) < 15);
      set_random();
      cycle(rdy, cap);
    end
    chk("t6_drains", 64'(drains - d0), 64'(20));
    chk("t6_beats",  64'(beats_seen - b0), 64'(20 * H));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
